design_select_ctrl: RTL

Sequencer that owns the select and reset controls of the top-level design multiplexer. It accepts "switch to design N" requests and drives `des_sel`, `hold_if_not_sel` and the shared `reset` line through a fixed, glitch-safe sequence. The outgoing design is reset before the select changes, and the incoming design is held in reset until the multiplexer's registered select decode has settled. It sits between the chip-level configuration logic (pins or scan) and the multiplexer.

---
 rtl/design_select_pkg.sv | 13 +
 rtl/design_select_ctrl_timer.sv | 24 ++
 rtl/design_select_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/design_select_pkg.sv
// Shared constants and state encoding for the design-select sequencer.
package design_select_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [1:0] {
        QUIESCE,
        SETTLE,
        RST_HOLD,
        RUN
    } ctrl_state_t;

endpackage

// File: rtl/design_select_ctrl_timer.sv
// Loadable down-counter that stops at zero; done flags a zero count.
module cycle_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/design_select_ctrl.sv
// Sequences design switches: reset the outgoing design, change the select,
// let the registered decode settle, then hold the incoming design in reset.
module design_select_ctrl
    import design_select_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,
    parameter int               RESET_CYCLES  = 4,
    parameter logic [SEL_W-1:0] IDLE_SEL      = '0,
    parameter logic             IDLE_HOLD     = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_hold,
    input  logic             ext_reset_req,
    output logic [SEL_W-1:0] des_sel,
    output logic             hold_if_not_sel,
    output logic             des_reset,
    output logic             busy
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic             accept;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_en;
    logic             timer_done;
    logic [SEL_W-1:0] target_sel;
    logic             held_hold;

    assign accept   = req_valid & req_ready;
    assign timer_en = (state == SETTLE) || (state == RST_HOLD);

    cycle_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clock      (clock),
        .load       (timer_load),
        .load_value (timer_value),
        .count_en   (timer_en),
        .done       (timer_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = RESET_LOAD;
        case (state)
            RUN: begin
                if (accept) begin
                    next_state = QUIESCE;
                end
            end
            QUIESCE: begin
                next_state  = SETTLE;
                timer_load  = 1'b1;
                timer_value = SETTLE_LOAD;
            end
            SETTLE: begin
                if (timer_done) begin
                    next_state  = RST_HOLD;
                    timer_load  = 1'b1;
                    timer_value = RESET_LOAD;
                end
            end
            RST_HOLD: begin
                if (timer_done) begin
                    next_state = RUN;
                end
            end
        endcase
        if (reset) begin
            timer_load  = 1'b1;
            timer_value = RESET_LOAD;
        end
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            des_sel         <= IDLE_SEL;
            hold_if_not_sel <= 1'b1;
            des_reset       <= 1'b1;
            busy            <= 1'b1;
            req_ready       <= 1'b0;
            held_hold       <= IDLE_HOLD;
            target_sel      <= IDLE_SEL;
        end else begin
            busy            <= (next_state != RUN);
            req_ready       <= (next_state == RUN);
            hold_if_not_sel <= (next_state == RUN) ? held_hold : 1'b1;
            des_reset       <= (next_state == RUN) ? ((state == RUN) && ext_reset_req) : 1'b1;
            if (accept) begin
                target_sel <= req_sel;
                held_hold  <= req_hold;
            end
            if (state == QUIESCE) begin
                des_sel <= target_sel;
            end
        end
    end

endmodule
